// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the CPU clock sequencer: FSM state encoding and
// the auto-mode half-period calculation.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AUTO_HI = 3'd1,
    AUTO_LO = 3'd2,
    STEP_HI = 3'd3,
    STEP_LO = 3'd4
  } seq_state_t;

  // Each speed_sel step divides the half-period by 4; the result never drops below one cycle.
  function automatic logic [31:0] half_period(input logic [1:0]  speed_sel,
                                              input logic [31:0] base);
    logic [31:0] shifted;
    shifted = base >> {speed_sel, 1'b0};
    return (shifted == '0) ? 32'd1 : shifted;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous level, with a registered level
// output and a registered one-cycle rising-edge pulse aligned to it.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: the synchronizer flops are reset so a level that is already high at
  // reset release is reported as a fresh rising edge rather than ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Generates the CPU core clock from the board clock: free-running divided clock
// in auto mode, or one full cpu_clk period per step request.
module cpu_clock_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned AUTO_HALF_PERIOD = 50_000_000,
  parameter int unsigned STEP_HALF_CYCLES = 8,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_auto_en,
  input  logic                 clk_step,
  input  logic [1:0]           speed_sel,
  output logic                 cpu_clk,
  output logic                 cpu_clk_rise,
  output logic                 busy,
  output logic                 step_dropped,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned MAX_HALF = (AUTO_HALF_PERIOD > STEP_HALF_CYCLES) ?
                                     AUTO_HALF_PERIOD : STEP_HALF_CYCLES;
  localparam int unsigned HCW = $clog2(MAX_HALF + 1);
  localparam logic [HCW-1:0] STEP_LAST = HCW'(STEP_HALF_CYCLES - 1);

  logic       auto_sync, auto_rise_unused;
  logic       step_level_unused, step_rise;
  logic [1:0] speed_sync, speed_rise_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_auto (
    .clk(clk), .rst(rst), .async_in(clk_auto_en), .level(auto_sync), .rise(auto_rise_unused)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .rst(rst), .async_in(clk_step), .level(step_level_unused), .rise(step_rise)
  );

  for (genvar b = 0; b < 2; b++) begin : g_speed_sync
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_speed (
      .clk(clk), .rst(rst), .async_in(speed_sel[b]), .level(speed_sync[b]),
      .rise(speed_rise_unused[b])
    );
  end

  seq_state_t     state, state_n;
  logic [HCW-1:0] cnt, cnt_n;
  logic [HCW-1:0] h_q, h_n, cur_h;
  logic           pending, pending_n;
  logic           dropped_n;
  logic           enter_hi;

  assign cur_h = HCW'(half_period(speed_sync, 32'(AUTO_HALF_PERIOD)));

  // NOTE: every variable written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + HCW'(1);
    h_n       = h_q;
    pending_n = pending;
    dropped_n = step_dropped;
    enter_hi  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (auto_sync) begin
          state_n  = AUTO_HI;
          h_n      = cur_h;
          enter_hi = 1'b1;
          if (step_rise) dropped_n = 1'b1;
        end else if (step_rise || pending) begin
          state_n   = STEP_HI;
          enter_hi  = 1'b1;
          // A fresh edge arriving while a queued step is consumed takes its place.
          pending_n = step_rise && pending;
        end
      end

      AUTO_HI: begin
        if (step_rise) dropped_n = 1'b1;
        if (cnt == h_q - HCW'(1)) begin
          cnt_n = '0;
          if (auto_sync) begin
            state_n = AUTO_LO;
            h_n     = cur_h;
          end else begin
            state_n = IDLE;
          end
        end
      end

      AUTO_LO: begin
        if (step_rise) dropped_n = 1'b1;
        if (!auto_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == h_q - HCW'(1)) begin
          state_n  = AUTO_HI;
          h_n      = cur_h;
          cnt_n    = '0;
          enter_hi = 1'b1;
        end
      end

      STEP_HI, STEP_LO: begin
        if (step_rise) begin
          if (pending) dropped_n = 1'b1;
          else         pending_n = 1'b1;
        end
        if (cnt == STEP_LAST) begin
          cnt_n   = '0;
          state_n = (state == STEP_HI) ? STEP_LO : IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // NOTE: state and outputs update only with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      h_q          <= HCW'(1);
      pending      <= 1'b0;
      step_dropped <= 1'b0;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      busy         <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      h_q          <= h_n;
      pending      <= pending_n;
      step_dropped <= dropped_n;
      cpu_clk      <= (state_n == AUTO_HI) || (state_n == STEP_HI);
      cpu_clk_rise <= enter_hi;
      busy         <= (state_n != IDLE);
      if (enter_hi) cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

endmodule
